lcd_byte_sequencer: RTL and testbench
=====================================

# lcd_byte_sequencer

Sequences byte writes to the 4-bit character LCD used by the MiniAlu board design. It runs the power-on initialisation, then accepts one byte at a time from the ALU's LCD/BNLCD instruction path over a ready/valid handshake. Each byte is split into two nibble strobes with controlled setup, enable-pulse and settle times. It sits between the ALU's LCD data register and the LCD pins, so the ALU never has to time an LCD strobe itself.

## Interface
Parameters (cycle counts at the 50 MHz Clock):
- INIT_WAIT, 750000: power-up wait before the first strobe (15 ms)
- INIT_WAIT1, 205000: wait after the first 0x3 init nibble (4.1 ms)
- INIT_WAIT2, 5000: wait after the second and third 0x3 nibbles and after the 0x2 nibble (100 us)
- SETUP, 2: cycles data/RS are stable before E rises
- EN_HIGH, 12: cycles E is held high
- NIB_GAP, 50: cycles E is low after each strobe
- CMD_WAIT, 2000: settle time after a normal byte (40 us)
- CLEAR_WAIT, 82000: settle time after command 0x01 or 0x02 (1.64 ms)

Ports:
- Clock  in  1  system clock, all state on posedge
- Reset  in  1  asynchronous, active-low; one clock domain
- iData  in  8  byte to write
- iRS  in  1  0 = command byte, 1 = data byte
- iData_Ready  in  1  requester has a valid byte
- oReadyForData  out  1  sequencer idle, byte will be accepted
- oInitDone  out  1  initialisation finished (sticky until reset)
- oLCD_Enabled  out  1  LCD E strobe
- oLCD_RegisterSelect  out  1  LCD RS
- oLCD_ReadWrite  out  1  constant 0 (write only)
- oLCD_StrataFlashControl  out  1  constant 1 (keeps StrataFlash off the shared bus)
- oLCD_Data  out  4  LCD DB[7:4]

## Operation
- Reset values (Reset = 0, applied asynchronously): oReadyForData = 0, oInitDone = 0, oLCD_Enabled = 0, oLCD_RegisterSelect = 0, oLCD_Data = 0x0, oLCD_ReadWrite = 0, oLCD_StrataFlashControl = 1. All counters clear and the state goes to INIT_WAIT.
- States: INIT_WAIT, INIT_NIB, INIT_CFG, IDLE, NIB_HI, NIB_LO, SETTLE.
- INIT_WAIT: count INIT_WAIT cycles.
- INIT_NIB: single-nibble strobes with RS = 0, in this order:
  - 0x3, then wait INIT_WAIT1
  - 0x3, then wait INIT_WAIT2
  - 0x3, then wait INIT_WAIT2
  - 0x2, then wait INIT_WAIT2
- INIT_CFG: full byte commands through the normal NIB_HI/NIB_LO/SETTLE path, in order 0x28, 0x06, 0x0C, 0x01. The 0x01 uses CLEAR_WAIT. Then oInitDone = 1 and the state goes to IDLE.
- Nibble strobe:
  - Drive data and RS; E = 0 for SETUP cycles.
  - E = 1 for EN_HIGH cycles.
  - E = 0 for NIB_GAP cycles.
  - Data and RS hold for the whole strobe.
- IDLE: oReadyForData = 1, oLCD_Data = 0x0, E = 0.
- Byte accept: iData_Ready = 1 sampled at a posedge while in IDLE latches iData and iRS. At that edge the state goes to NIB_HI and oReadyForData drops.
- NIB_HI sends latched [7:4]; NIB_LO sends [3:0]. RS equals the latched iRS for both nibbles.
- SETTLE wait length:
  - CLEAR_WAIT if iRS = 0 and the byte is 0x01 or 0x02.
  - CMD_WAIT otherwise, including data bytes equal to 0x01 or 0x02.
- iData_Ready while oReadyForData = 0 is ignored. There is no queue; the requester must hold the request until accepted.
- iData and iRS changes after acceptance have no effect on the byte in flight.
- Counters are wide enough for the largest parameter and compare against parameter − 1 with no wrap. A parameter value of 0 is illegal.

## Timing
- Single-nibble strobe length: S = SETUP + EN_HIGH + NIB_GAP cycles.
- Take the accept edge as edge 0:
  - E is high on edges SETUP+1 .. SETUP+EN_HIGH for the high nibble.
  - E is high on edges S+SETUP+1 .. S+SETUP+EN_HIGH for the low nibble.
  - oReadyForData returns to 1 at edge 2S + W + 1, where W is the applicable settle time.
- Back-to-back: with iData_Ready held high, the next byte is accepted at the first edge on which oReadyForData = 1. Throughput is one byte per 2S + W + 1 cycles.
- oReadyForData stays 0 until the 0x01 settle finishes.
- Reset asserted mid-strobe: E falls immediately (asynchronously) and the latched byte is discarded. After release the full init sequence reruns and oInitDone stays 0 until it completes.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
Use INIT_WAIT=20, INIT_WAIT1=10, INIT_WAIT2=5, SETUP=2, EN_HIGH=3, NIB_GAP=4, CMD_WAIT=6, CLEAR_WAIT=15 (S = 9).
- Release reset, no requests -> E pulses carry nibbles 3,3,3,2, then 2,8,0,6,0,C,0,1, all with RS=0 and each E pulse 3 cycles; oInitDone rises after the 0x01 settle and oReadyForData = 1.
- After init, iData=0x41, iRS=1 for one edge -> nibbles 4 then 1 with RS=1; E high on edges 3–5 and 12–14; oReadyForData back to 1 at edge 25.
- iData=0x01, iRS=0 -> RS=0, settle 15 cycles, ready at edge 34. Then iData=0x01, iRS=1 -> settle 6 cycles, ready at edge 25.
- Hold iData_Ready=1 while changing iData 0x48→0x49 during the transfer -> the first byte is sent as 0x48; 0x49 is accepted on the edge where ready returns, with no idle gap.
- Pulse iData_Ready during init -> no extra strobes; the byte is not latched; oReadyForData stays 0 until oInitDone.
- Assert Reset during the high-nibble E pulse -> E = 0 and Data = 0x0 without waiting for a clock edge; after release the init sequence replays from INIT_WAIT.

Source files
------------

// File: rtl/lcd_byte_sequencer.sv
// Byte sequencer for a 4-bit character LCD: runs the power-on init sequence,
// then splits each accepted byte into two timed nibble strobes on DB[7:4].
module lcd_byte_sequencer #(
  parameter int unsigned INIT_WAIT  = 750000,
  parameter int unsigned INIT_WAIT1 = 205000,
  parameter int unsigned INIT_WAIT2 = 5000,
  parameter int unsigned SETUP      = 2,
  parameter int unsigned EN_HIGH    = 12,
  parameter int unsigned NIB_GAP    = 50,
  parameter int unsigned CMD_WAIT   = 2000,
  parameter int unsigned CLEAR_WAIT = 82000
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [7:0] iData,
  input  logic       iRS,
  input  logic       iData_Ready,
  output logic       oReadyForData,
  output logic       oInitDone,
  output logic       oLCD_Enabled,
  output logic       oLCD_RegisterSelect,
  output logic       oLCD_ReadWrite,
  output logic       oLCD_StrataFlashControl,
  output logic [3:0] oLCD_Data
);

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  localparam int unsigned MAX_CNT = max2(max2(max2(INIT_WAIT, INIT_WAIT1), max2(INIT_WAIT2, SETUP)),
                                         max2(max2(EN_HIGH, NIB_GAP), max2(CMD_WAIT, CLEAR_WAIT)));
  localparam int unsigned CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;

  localparam logic [CNT_W-1:0] L_INIT_WAIT  = CNT_W'(INIT_WAIT - 1);
  localparam logic [CNT_W-1:0] L_INIT_WAIT1 = CNT_W'(INIT_WAIT1 - 1);
  localparam logic [CNT_W-1:0] L_INIT_WAIT2 = CNT_W'(INIT_WAIT2 - 1);
  localparam logic [CNT_W-1:0] L_SETUP      = CNT_W'(SETUP - 1);
  localparam logic [CNT_W-1:0] L_EN_HIGH    = CNT_W'(EN_HIGH - 1);
  localparam logic [CNT_W-1:0] L_NIB_GAP    = CNT_W'(NIB_GAP - 1);
  localparam logic [CNT_W-1:0] L_CMD_WAIT   = CNT_W'(CMD_WAIT - 1);
  localparam logic [CNT_W-1:0] L_CLEAR_WAIT = CNT_W'(CLEAR_WAIT - 1);

  typedef enum logic [2:0] {
    S_INIT_WAIT, S_INIT_NIB, S_INIT_CFG, S_IDLE, S_NIB_HI, S_NIB_LO, S_SETTLE
  } state_t;

  typedef enum logic [1:0] {PH_SETUP, PH_EN, PH_GAP, PH_WAIT} phase_t;

  function automatic logic [3:0] init_nibble(input logic [1:0] idx);
    return (idx == 2'd3) ? 4'h2 : 4'h3;
  endfunction

  function automatic logic [7:0] cfg_byte(input logic [1:0] idx);
    unique case (idx)
      2'd0:    return 8'h28;
      2'd1:    return 8'h06;
      2'd2:    return 8'h0C;
      default: return 8'h01;
    endcase
  endfunction

  state_t           state_q, state_d;
  phase_t           phase_q, phase_d, phase_adv;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_adv;
  logic [1:0]       idx_q, idx_d;
  logic [7:0]       byte_q, byte_d;
  logic             byte_rs_q, byte_rs_d;
  logic             init_done_q, init_done_d;
  logic             ready_q, ready_d;
  logic             en_q, en_d;
  logic             rs_q, rs_d;
  logic [3:0]       data_q, data_d;
  logic             strobe_end;
  logic [CNT_W-1:0] init_wait_lim, settle_lim;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    cnt_d       = cnt_q + 1'b1;
    idx_d       = idx_q;
    byte_d      = byte_q;
    byte_rs_d   = byte_rs_q;
    init_done_d = init_done_q;

    // Shared setup -> enable -> gap progression for every nibble strobe.
    phase_adv = phase_q;
    cnt_adv   = cnt_q + 1'b1;
    if (phase_q == PH_SETUP && cnt_q == L_SETUP) begin
      phase_adv = PH_EN;
      cnt_adv   = '0;
    end else if (phase_q == PH_EN && cnt_q == L_EN_HIGH) begin
      phase_adv = PH_GAP;
      cnt_adv   = '0;
    end
    strobe_end    = (phase_q == PH_GAP) && (cnt_q == L_NIB_GAP);
    init_wait_lim = (idx_q == 2'd0) ? L_INIT_WAIT1 : L_INIT_WAIT2;
    // Clear/home are slow only as commands; the same codes as data are ordinary.
    settle_lim    = (!byte_rs_q && (byte_q == 8'h01 || byte_q == 8'h02)) ? L_CLEAR_WAIT : L_CMD_WAIT;

    unique case (state_q)
      S_INIT_WAIT: begin
        if (cnt_q == L_INIT_WAIT) begin
          state_d = S_INIT_NIB;
          phase_d = PH_SETUP;
          cnt_d   = '0;
          idx_d   = '0;
        end
      end
      S_INIT_NIB: begin
        if (phase_q == PH_WAIT) begin
          if (cnt_q == init_wait_lim) begin
            phase_d = PH_SETUP;
            cnt_d   = '0;
            if (idx_q == 2'd3) begin
              state_d = S_INIT_CFG;
              idx_d   = '0;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end
        end else if (strobe_end) begin
          phase_d = PH_WAIT;
          cnt_d   = '0;
        end else begin
          phase_d = phase_adv;
          cnt_d   = cnt_adv;
        end
      end
      S_INIT_CFG: begin
        byte_d    = cfg_byte(idx_q);
        byte_rs_d = 1'b0;
        state_d   = S_NIB_HI;
        phase_d   = PH_SETUP;
        cnt_d     = '0;
      end
      S_IDLE: begin
        cnt_d = '0;
        if (iData_Ready) begin
          byte_d    = iData;
          byte_rs_d = iRS;
          state_d   = S_NIB_HI;
          phase_d   = PH_SETUP;
        end
      end
      S_NIB_HI: begin
        if (strobe_end) begin
          state_d = S_NIB_LO;
          phase_d = PH_SETUP;
          cnt_d   = '0;
        end else begin
          phase_d = phase_adv;
          cnt_d   = cnt_adv;
        end
      end
      S_NIB_LO: begin
        if (strobe_end) begin
          state_d = S_SETTLE;
          cnt_d   = '0;
        end else begin
          phase_d = phase_adv;
          cnt_d   = cnt_adv;
        end
      end
      S_SETTLE: begin
        if (cnt_q == settle_lim) begin
          cnt_d = '0;
          if (init_done_q || idx_q == 2'd3) begin
            state_d     = S_IDLE;
            init_done_d = 1'b1;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = S_INIT_CFG;
          end
        end
      end
      default: begin
        state_d = S_INIT_WAIT;
        cnt_d   = '0;
      end
    endcase

    // Pin values are decoded from the next state so every output is a flop.
    en_d    = (phase_d == PH_EN) &&
              (state_d == S_INIT_NIB || state_d == S_NIB_HI || state_d == S_NIB_LO);
    rs_d    = (state_d == S_NIB_HI || state_d == S_NIB_LO) ? byte_rs_d : 1'b0;
    ready_d = (state_d == S_IDLE);
    unique case (state_d)
      S_INIT_NIB: data_d = (phase_d == PH_WAIT) ? 4'h0 : init_nibble(idx_d);
      S_NIB_HI:   data_d = byte_d[7:4];
      S_NIB_LO:   data_d = byte_d[3:0];
      default:    data_d = 4'h0;
    endcase
  end

  // NOTE: state flops take non-blocking assignments so every flop samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q     <= S_INIT_WAIT;
      phase_q     <= PH_SETUP;
      cnt_q       <= '0;
      idx_q       <= '0;
      byte_q      <= '0;
      byte_rs_q   <= 1'b0;
      init_done_q <= 1'b0;
      ready_q     <= 1'b0;
      en_q        <= 1'b0;
      rs_q        <= 1'b0;
      data_q      <= 4'h0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      byte_q      <= byte_d;
      byte_rs_q   <= byte_rs_d;
      init_done_q <= init_done_d;
      ready_q     <= ready_d;
      en_q        <= en_d;
      rs_q        <= rs_d;
      data_q      <= data_d;
    end
  end

  assign oReadyForData           = ready_q;
  assign oInitDone               = init_done_q;
  assign oLCD_Enabled            = en_q;
  assign oLCD_RegisterSelect     = rs_q;
  assign oLCD_Data               = data_q;
  assign oLCD_ReadWrite          = 1'b0;
  assign oLCD_StrataFlashControl = 1'b1;

endmodule

// File: tb/tb_lcd_byte_sequencer.sv
// Self-checking bench for lcd_byte_sequencer: scoreboard of expected nibble
// strobes plus a table of single-byte transfers and hand-written corner cases.
module tb_lcd_byte_sequencer;

  localparam int unsigned INIT_WAIT  = 20;
  localparam int unsigned INIT_WAIT1 = 10;
  localparam int unsigned INIT_WAIT2 = 5;
  localparam int unsigned SETUP      = 2;
  localparam int unsigned EN_HIGH    = 3;
  localparam int unsigned NIB_GAP    = 4;
  localparam int unsigned CMD_WAIT   = 6;
  localparam int unsigned CLEAR_WAIT = 15;

  typedef struct {
    logic       rs;
    logic [3:0] nib;
    int         at_edge;   // -1: edge not checked
  } strobe_t;

  typedef struct {
    logic [7:0] d;
    logic       rs;
    int         ready_edge;
  } vec_t;

  logic       clk;
  logic       rst_n;
  logic [7:0] data_in;
  logic       rs_in;
  logic       valid;
  logic       ready;
  logic       init_done;
  logic       lcd_e;
  logic       lcd_rs;
  logic       lcd_rw;
  logic       lcd_sf;
  logic [3:0] lcd_data;

  int      n_checks = 0;
  int      n_pass   = 0;
  int      cyc      = 0;
  bit      ready_early = 0;
  strobe_t sb[$];
  vec_t    vecs[7];

  lcd_byte_sequencer #(
    .INIT_WAIT(INIT_WAIT), .INIT_WAIT1(INIT_WAIT1), .INIT_WAIT2(INIT_WAIT2),
    .SETUP(SETUP), .EN_HIGH(EN_HIGH), .NIB_GAP(NIB_GAP),
    .CMD_WAIT(CMD_WAIT), .CLEAR_WAIT(CLEAR_WAIT)
  ) dut (
    .Clock                  (clk),
    .Reset                  (rst_n),
    .iData                  (data_in),
    .iRS                    (rs_in),
    .iData_Ready            (valid),
    .oReadyForData          (ready),
    .oInitDone              (init_done),
    .oLCD_Enabled           (lcd_e),
    .oLCD_RegisterSelect    (lcd_rs),
    .oLCD_ReadWrite         (lcd_rw),
    .oLCD_StrataFlashControl(lcd_sf),
    .oLCD_Data              (lcd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
  endtask

  task automatic push_init();
    logic [3:0] seq [12] = '{4'h3, 4'h3, 4'h3, 4'h2, 4'h2, 4'h8, 4'h0, 4'h6, 4'h0, 4'hC, 4'h0, 4'h1};
    for (int i = 0; i < 12; i++) sb.push_back('{1'b0, seq[i], -1});
  endtask

  // Observed edge index of a sample taken at a negedge is cyc + 1.
  initial begin : monitor
    bit      prev_e;
    int      width;
    strobe_t want;
    prev_e = 1'b0;
    width  = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_e = 1'b0;
        width  = 0;
      end else begin
        if (lcd_e && !prev_e) begin
          if (sb.size() == 0) begin
            check("unexpected_strobe", {28'd0, lcd_data}, 32'hFFFF_FFFF);
          end else begin
            want = sb.pop_front();
            check("strobe_nib", {28'd0, lcd_data}, {28'd0, want.nib});
            check("strobe_rs", {31'd0, lcd_rs}, {31'd0, want.rs});
            if (want.at_edge >= 0) check("strobe_edge", cyc + 1, want.at_edge);
          end
          width = 1;
        end else if (lcd_e) begin
          width++;
        end else if (prev_e) begin
          check("e_width", width, EN_HIGH);
        end
        if (ready && !init_done) ready_early = 1'b1;
        prev_e = lcd_e;
      end
    end
  end

  // Runs at negedges after reset release; optionally pokes iData_Ready mid-init.
  task automatic wait_init(input int rel, input bit poke);
    int first_e = -1;
    for (int i = 0; i < 2000 && !init_done; i++) begin
      if (lcd_e && first_e < 0) first_e = cyc + 1;
      if (poke && (i == 40 || i == 120)) begin
        valid = 1'b1; data_in = 8'h55; rs_in = 1'b1;
      end else begin
        valid = 1'b0;
      end
      @(negedge clk);
    end
    valid = 1'b0;
    check("init_done", {31'd0, init_done}, 32'd1);
    check("ready_after_init", {31'd0, ready}, 32'd1);
    check("init_wait_len", {31'd0, (first_e - rel) >= int'(INIT_WAIT)}, 32'd1);
    check("init_sb_empty", sb.size(), 0);
  endtask

  task automatic send_vec(input vec_t v);
    int acc;
    for (int i = 0; i < 200 && !ready; i++) @(negedge clk);
    if (!ready) begin
      check("ready_wait_timeout", 32'd0, 32'd1);
      return;
    end
    data_in = v.d; rs_in = v.rs; valid = 1'b1;
    acc = cyc + 1;
    sb.push_back('{v.rs, v.d[7:4], acc + 3});
    sb.push_back('{v.rs, v.d[3:0], acc + 12});
    @(negedge clk);
    valid = 1'b0; data_in = ~v.d; rs_in = ~v.rs;
    for (int i = 0; i < 200 && !ready; i++) @(negedge clk);
    check("ready_edge", cyc + 1 - acc, v.ready_edge);
    check("byte_sb_empty", sb.size(), 0);
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin : main
    int acc;
    int rel;
    vecs[0] = '{8'h41, 1'b1, 25};
    vecs[1] = '{8'h01, 1'b0, 34};
    vecs[2] = '{8'h01, 1'b1, 25};
    vecs[3] = '{8'h02, 1'b0, 34};
    vecs[4] = '{8'h02, 1'b1, 25};
    vecs[5] = '{8'hA5, 1'b0, 25};
    vecs[6] = '{8'h03, 1'b0, 25};

    rst_n = 1'b0; data_in = 8'h00; rs_in = 1'b0; valid = 1'b0;
    #3;
    check("rst_ready", {31'd0, ready}, 32'd0);
    check("rst_init_done", {31'd0, init_done}, 32'd0);
    check("rst_e", {31'd0, lcd_e}, 32'd0);
    check("rst_rs", {31'd0, lcd_rs}, 32'd0);
    check("rst_data", {28'd0, lcd_data}, 32'd0);
    check("rst_rw", {31'd0, lcd_rw}, 32'd0);
    check("rst_sf", {31'd0, lcd_sf}, 32'd1);

    // Power-up init, with stray requests that must be ignored.
    push_init();
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    rel = cyc;
    check("init_done_low_at_release", {31'd0, init_done}, 32'd0);
    wait_init(rel, 1'b1);
    repeat (5) @(negedge clk);
    check("no_ready_before_init", {31'd0, ready_early}, 32'd0);
    check("idle_ready", {31'd0, ready}, 32'd1);
    check("idle_data", {28'd0, lcd_data}, 32'd0);

    for (int i = 0; i < 7; i++) send_vec(vecs[i]);

    // Back-to-back with data changing after acceptance.
    for (int i = 0; i < 200 && !ready; i++) @(negedge clk);
    data_in = 8'h48; rs_in = 1'b1; valid = 1'b1;
    acc = cyc + 1;
    sb.push_back('{1'b1, 4'h4, acc + 3});
    sb.push_back('{1'b1, 4'h8, acc + 12});
    sb.push_back('{1'b1, 4'h4, acc + 28});
    sb.push_back('{1'b1, 4'h9, acc + 37});
    @(negedge clk);
    data_in = 8'h49;
    for (int i = 0; i < 200 && !ready; i++) @(negedge clk);
    check("b2b_ready_edge", cyc + 1 - acc, 25);
    @(negedge clk);
    valid = 1'b0; data_in = 8'h00;
    check("b2b_second_accepted", {31'd0, ready}, 32'd0);
    for (int i = 0; i < 200 && !ready; i++) @(negedge clk);
    check("b2b_second_ready_edge", cyc + 1 - (acc + 25), 25);
    check("b2b_sb_empty", sb.size(), 0);

    // Reset during the high-nibble enable pulse.
    for (int i = 0; i < 200 && !ready; i++) @(negedge clk);
    data_in = 8'h41; rs_in = 1'b1; valid = 1'b1;
    acc = cyc + 1;
    sb.push_back('{1'b1, 4'h4, acc + 3});
    @(negedge clk);
    valid = 1'b0;
    for (int i = 0; i < 20 && !lcd_e; i++) @(negedge clk);
    check("mid_strobe_e_seen", {31'd0, lcd_e}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_e", {31'd0, lcd_e}, 32'd0);
    check("async_rst_data", {28'd0, lcd_data}, 32'd0);
    check("async_rst_init_done", {31'd0, init_done}, 32'd0);
    check("async_rst_ready", {31'd0, ready}, 32'd0);
    sb.delete();
    @(negedge clk); @(negedge clk);
    push_init();
    rst_n = 1'b1;
    rel = cyc;
    check("reinit_done_low", {31'd0, init_done}, 32'd0);
    wait_init(rel, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
